// File: rtl/gf2m_inv_ctrl.sv
// rtl/gf2m_inv_ctrl.sv - Fermat inverter a^(2^m-2) sequencing an external GF(2^m) multiplier
// Schedule: r=a; (WIDTH-2) x {r=r*r; r=r*a}; r=r*r, one multiplier call per ISSUE/WAIT pair.
module gf2m_inv_ctrl #(
   parameter int WIDTH = 127,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] op_inv,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_op_a,
   output logic [WIDTH-1:0] mul_op_b,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_op_c
);

   typedef enum logic [2:0] {S_IDLE, S_ZERO, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {PH_SQR, PH_MUL, PH_FSQ} phase_t;

   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 2);

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] inv_q, inv_d;
   logic [WIDTH-1:0] mop_a_q, mop_a_d;
   logic [WIDTH-1:0] mop_b_q, mop_b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    cnt_inc;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             mstart_q, mstart_d;

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      a_d      = a_q;
      r_d      = r_q;
      inv_d    = inv_q;
      mop_a_d  = mop_a_q;
      mop_b_d  = mop_b_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      err_d    = err_q;
      done_d   = 1'b0;
      mstart_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d  = 1'b0;
               busy_d = 1'b1;
               if (op_a == '0) begin
                  state_d = S_ZERO;
               end else begin
                  state_d  = S_ISSUE;
                  a_d      = op_a;
                  r_d      = op_a;
                  cnt_d    = '0;
                  phase_d  = PH_SQR;
                  mop_a_d  = op_a;
                  mop_b_d  = op_a;
                  mstart_d = 1'b1;
               end
            end
         end
         S_ZERO: begin
            inv_d   = '0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done) begin
               r_d = mul_op_c;
               case (phase_q)
                  PH_SQR:  phase_d = PH_MUL;
                  PH_MUL: begin
                     cnt_d   = cnt_inc;
                     phase_d = (cnt_inc == LAST_ITER) ? PH_FSQ : PH_SQR;
                  end
                  default: phase_d = PH_FSQ;
               endcase
               if (phase_q == PH_FSQ) begin
                  inv_d   = mul_op_c;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  // operands are registered here so they are stable for the whole ISSUE/WAIT span
                  state_d  = S_ISSUE;
                  mstart_d = 1'b1;
                  mop_a_d  = mul_op_c;
                  mop_b_d  = (phase_d == PH_MUL) ? a_q : mul_op_c;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         phase_q  <= PH_SQR;
         a_q      <= '0;
         r_q      <= '0;
         inv_q    <= '0;
         mop_a_q  <= '0;
         mop_b_q  <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         mstart_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         a_q      <= a_d;
         r_q      <= r_d;
         inv_q    <= inv_d;
         mop_a_q  <= mop_a_d;
         mop_b_q  <= mop_b_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         mstart_q <= mstart_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign op_inv    = inv_q;
   assign mul_start = mstart_q;
   assign mul_op_a  = mop_a_q;
   assign mul_op_b  = mop_b_q;

endmodule
